// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter_if
// Brief   : Requester and memory-side bus bundle for the data-memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if;
    logic        Req0, Req1;
    logic        We0, We1;
    logic [31:0] Addr0, Addr1;
    logic [31:0] WData0, WData1;
    logic        Gnt0, Gnt1;
    logic        Done0, Done1;
    logic        Err0, Err1;
    logic [31:0] RData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEnable;
    logic        MemRead;
    logic [31:0] MemReadData;

    modport slave (
        input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, MemReadData,
        output Gnt0, Gnt1, Done0, Done1, Err0, Err1, RData,
               MemAddress, MemWriteData, MemWriteEnable, MemRead
    );

    modport master (
        output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, MemReadData,
        input  Gnt0, Gnt1, Done0, Done1, Err0, Err1, RData,
               MemAddress, MemWriteData, MemWriteEnable, MemRead
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-port arbiter/sequencer in front of a single-port data memory.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH      = 1024,
    parameter int AW         = 10,
    parameter int FIXED_PRIO = 0
) (
    input  logic          Clock,
    input  logic          Reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [31:0] c_depth = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      r_state, w_state_nx;
    logic        r_owner, w_owner;
    logic        r_we, w_we;
    logic        r_oor, w_oor;
    logic        r_last, w_last;
    logic [1:0]  r_gnt, w_gnt;
    logic [1:0]  r_done, w_done;
    logic [1:0]  r_err, w_err;
    logic [31:0] r_rdata, w_rdata;
    logic [31:0] r_mem_addr, w_mem_addr;
    logic [31:0] r_mem_wdata, w_mem_wdata;
    logic        r_mem_we, w_mem_we;
    logic        r_mem_rd, w_mem_rd;

    logic        w_sel;
    logic        w_sel_we;
    logic        w_sel_oor;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    // Round-robin tie-break favours the port that did not win last time.
    always_comb begin
        if (bus.Req0 && bus.Req1) begin
            w_sel = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        end else begin
            w_sel = bus.Req1;
        end
        w_sel_we    = w_sel ? bus.We1    : bus.We0;
        w_sel_addr  = w_sel ? bus.Addr1  : bus.Addr0;
        w_sel_wdata = w_sel ? bus.WData1 : bus.WData0;
        w_sel_oor   = (w_sel_addr >= c_depth);
    end

    always_comb begin
        w_state_nx  = r_state;
        w_owner     = r_owner;
        w_we        = r_we;
        w_oor       = r_oor;
        w_last      = r_last;
        w_gnt       = 2'b00;
        w_done      = 2'b00;
        w_err       = 2'b00;
        w_rdata     = r_rdata;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        w_mem_rd    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    w_state_nx   = ISSUE;
                    w_owner      = w_sel;
                    w_last       = w_sel;
                    w_we         = w_sel_we;
                    w_oor        = w_sel_oor;
                    w_gnt[w_sel] = 1'b1;
                    // Memory lines are registered, so they are loaded now to be live during ISSUE.
                    if (!w_sel_oor) begin
                        w_mem_addr  = {{(32-AW){1'b0}}, w_sel_addr[AW-1:0]};
                        w_mem_wdata = w_sel_wdata;
                        w_mem_we    = w_sel_we;
                        w_mem_rd    = ~w_sel_we;
                    end
                end
            end
            ISSUE: begin
                if (!r_we && !r_oor) begin
                    w_state_nx = CAPTURE;
                end else begin
                    w_state_nx       = IDLE;
                    w_done[r_owner]  = 1'b1;
                    w_err[r_owner]   = r_oor;
                    if (r_oor) begin
                        w_rdata = '0;
                    end
                end
            end
            CAPTURE: begin
                w_state_nx      = IDLE;
                w_rdata         = bus.MemReadData;
                w_done[r_owner] = 1'b1;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_last      <= 1'b1;
            r_gnt       <= 2'b00;
            r_done      <= 2'b00;
            r_err       <= 2'b00;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_rd    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_owner     <= w_owner;
            r_we        <= w_we;
            r_oor       <= w_oor;
            r_last      <= w_last;
            r_gnt       <= w_gnt;
            r_done      <= w_done;
            r_err       <= w_err;
            r_rdata     <= w_rdata;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_we    <= w_mem_we;
            r_mem_rd    <= w_mem_rd;
        end
    end

    assign bus.Gnt0           = r_gnt[0];
    assign bus.Gnt1           = r_gnt[1];
    assign bus.Done0          = r_done[0];
    assign bus.Done1          = r_done[1];
    assign bus.Err0           = r_err[0];
    assign bus.Err1           = r_err[1];
    assign bus.RData          = r_rdata;
    assign bus.MemAddress     = r_mem_addr;
    assign bus.MemWriteData   = r_mem_wdata;
    assign bus.MemWriteEnable = r_mem_we;
    assign bus.MemRead        = r_mem_rd;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Scoreboard bench for dmem_arbiter (round-robin and fixed-priority).
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus_fp();

    dmem_arbiter #(.DEPTH(1024), .AW(10), .FIXED_PRIO(0)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus.slave)
    );
    dmem_arbiter #(.DEPTH(1024), .AW(10), .FIXED_PRIO(1)) dut_fp (
        .Clock(Clock), .Reset(Reset), .bus(bus_fp.slave)
    );

    // Single-port memories: write and registered read on the rising edge.
    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];
    always @(posedge Clock) begin
        if (bus.MemWriteEnable) mem0[bus.MemAddress[9:0]] <= bus.MemWriteData;
        if (bus.MemRead)        bus.MemReadData <= mem0[bus.MemAddress[9:0]];
        if (bus_fp.MemWriteEnable) mem1[bus_fp.MemAddress[9:0]] <= bus_fp.MemWriteData;
        if (bus_fp.MemRead)        bus_fp.MemReadData <= mem1[bus_fp.MemAddress[9:0]];
    end

    typedef struct {
        logic        port;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [0:1023];
    int          vectors;
    int          miscompares;

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic push_exp(input logic port, input logic err, input logic chk, input logic [31:0] rdata);
        exp_t x;
        x.port = port; x.err = err; x.chk = chk; x.rdata = rdata;
        sb.push_back(x);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        step; step;
        vectors++;
        if ({bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1, bus.Err0, bus.Err1, bus.RData, bus.MemAddress,
             bus.MemWriteData, bus.MemWriteEnable, bus.MemRead} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: gnt=%b%b done=%b%b rdata=%h maddr=%h want all 0",
                     bus.Gnt1, bus.Gnt0, bus.Done1, bus.Done0, bus.RData, bus.MemAddress);
        end
        vectors++;
        if ({bus_fp.Gnt0, bus_fp.Gnt1, bus_fp.Done0, bus_fp.Done1, bus_fp.RData,
             bus_fp.MemWriteEnable, bus_fp.MemRead} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs_fp: gnt=%b%b done=%b%b want all 0",
                     bus_fp.Gnt1, bus_fp.Gnt0, bus_fp.Done1, bus_fp.Done0);
        end
        Reset = 1'b0;
        step;
    endtask

    task automatic test_write;
        exp_t e;
        bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 32'd5; bus.WData0 = 32'hDEADBEEF;
        model[5] = 32'hDEADBEEF;
        push_exp(1'b0, 1'b0, 1'b0, 32'h0);
        step;
        vectors++;
        if (!(bus.Gnt0 === 1'b1 && bus.Gnt1 === 1'b0 && bus.MemWriteEnable === 1'b1 && bus.MemRead === 1'b0
              && bus.MemAddress === 32'd5 && bus.MemWriteData === 32'hDEADBEEF)) begin
            miscompares++;
            $display("FAIL wr_gnt: gnt=%b%b we=%b rd=%b maddr=%h wd=%h want gnt=01 we=1 rd=0 maddr=5 wd=deadbeef",
                     bus.Gnt1, bus.Gnt0, bus.MemWriteEnable, bus.MemRead, bus.MemAddress, bus.MemWriteData);
        end
        bus.Req0 = 1'b0;
        step;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++; $display("FAIL wr_done: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({bus.Done1, bus.Done0} !== (e.port ? 2'b10 : 2'b01) || {bus.Err1, bus.Err0} !== 2'b00
                || bus.MemWriteEnable !== 1'b0) begin
                miscompares++;
                $display("FAIL wr_done: done=%b err=%b mwe=%b want done=01 err=00 mwe=0",
                         {bus.Done1, bus.Done0}, {bus.Err1, bus.Err0}, bus.MemWriteEnable);
            end
        end
    endtask

    task automatic test_read;
        exp_t e;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 32'd5;
        push_exp(1'b1, 1'b0, 1'b1, model[5]);
        step;
        vectors++;
        if (!(bus.Gnt1 === 1'b1 && bus.Gnt0 === 1'b0 && bus.MemRead === 1'b1 && bus.MemWriteEnable === 1'b0
              && bus.MemAddress === 32'd5)) begin
            miscompares++;
            $display("FAIL rd_gnt: gnt=%b%b rd=%b we=%b maddr=%h want gnt=10 rd=1 we=0 maddr=5",
                     bus.Gnt1, bus.Gnt0, bus.MemRead, bus.MemWriteEnable, bus.MemAddress);
        end
        bus.Req1 = 1'b0;
        step;
        vectors++;
        if ({bus.Done1, bus.Done0, bus.MemRead, bus.MemWriteEnable} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rd_capture: done=%b%b rd=%b we=%b want all 0",
                     bus.Done1, bus.Done0, bus.MemRead, bus.MemWriteEnable);
        end
        step;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++; $display("FAIL rd_done: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({bus.Done1, bus.Done0} !== (e.port ? 2'b10 : 2'b01) || {bus.Err1, bus.Err0} !== 2'b00
                || bus.RData !== e.rdata) begin
                miscompares++;
                $display("FAIL rd_done: done=%b err=%b rdata=%h want done=10 err=00 rdata=%h",
                         {bus.Done1, bus.Done0}, {bus.Err1, bus.Err0}, bus.RData, e.rdata);
            end
        end
    endtask

    task automatic test_out_of_range;
        exp_t e;
        // Last legal word first, as a port 1 write.
        bus.Req1 = 1'b1; bus.We1 = 1'b1; bus.Addr1 = 32'd1023; bus.WData1 = 32'hA5A50001;
        model[1023] = 32'hA5A50001;
        push_exp(1'b1, 1'b0, 1'b0, 32'h0);
        step;
        vectors++;
        if (!(bus.Gnt1 === 1'b1 && bus.MemWriteEnable === 1'b1 && bus.MemAddress === 32'd1023)) begin
            miscompares++;
            $display("FAIL edge_gnt: gnt1=%b we=%b maddr=%h want 1 1 000003ff",
                     bus.Gnt1, bus.MemWriteEnable, bus.MemAddress);
        end
        bus.Req1 = 1'b0;
        step;
        vectors++;
        e = sb.pop_front();
        if ({bus.Done1, bus.Done0} !== 2'b10 || {bus.Err1, bus.Err0} !== {e.err, 1'b0}) begin
            miscompares++;
            $display("FAIL edge_done: done=%b err=%b want done=10 err=00", {bus.Done1, bus.Done0}, {bus.Err1, bus.Err0});
        end
        // First illegal word, as a port 0 read; RData currently holds the earlier read.
        bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 32'd1024;
        push_exp(1'b0, 1'b1, 1'b1, 32'h0);
        step;
        vectors++;
        if (!(bus.Gnt0 === 1'b1 && bus.MemRead === 1'b0 && bus.MemWriteEnable === 1'b0 && bus.MemAddress === 32'd0)) begin
            miscompares++;
            $display("FAIL oor_gnt: gnt0=%b rd=%b we=%b maddr=%h want 1 0 0 0",
                     bus.Gnt0, bus.MemRead, bus.MemWriteEnable, bus.MemAddress);
        end
        bus.Req0 = 1'b0;
        step;
        vectors++;
        e = sb.pop_front();
        if ({bus.Done1, bus.Done0} !== 2'b01 || {bus.Err1, bus.Err0} !== {1'b0, e.err} || bus.RData !== e.rdata
            || bus.MemRead !== 1'b0 || bus.MemWriteEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_done: done=%b err=%b rdata=%h rd=%b we=%b want done=01 err=01 rdata=0 rd=0 we=0",
                     {bus.Done1, bus.Done0}, {bus.Err1, bus.Err0}, bus.RData, bus.MemRead, bus.MemWriteEnable);
        end
    endtask

    task automatic test_arbitration;
        int ord[$];
        int last_gnt, n_gnt, n_done, fp_gnt0, fp_gnt1, p;
        Reset = 1'b1;
        bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 32'd10;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 32'd20;
        bus_fp.Req0 = 1'b1; bus_fp.We0 = 1'b0; bus_fp.Addr0 = 32'd10;
        bus_fp.Req1 = 1'b1; bus_fp.We1 = 1'b0; bus_fp.Addr1 = 32'd20;
        for (int i = 0; i < 4; i++) ord.push_back(i % 2);
        step;
        Reset = 1'b0;
        last_gnt = -2; n_gnt = 0; n_done = 0; fp_gnt0 = 0; fp_gnt1 = 0;
        for (int c = 1; c <= 12; c++) begin
            step;
            if (bus.Gnt0 || bus.Gnt1) begin
                vectors++;
                p = (ord.size() != 0) ? ord.pop_front() : -1;
                if ({bus.Gnt1, bus.Gnt0} !== (p == 1 ? 2'b10 : 2'b01) || p < 0 || c - last_gnt != 3) begin
                    miscompares++;
                    $display("FAIL rr_gnt: cycle=%0d gnt=%b gap=%0d want port=%0d gap=3",
                             c, {bus.Gnt1, bus.Gnt0}, c - last_gnt, p);
                end
                last_gnt = c;
                n_gnt++;
            end
            if (bus.Done0 || bus.Done1) begin
                vectors++;
                if (c % 3 != 0) begin
                    miscompares++;
                    $display("FAIL rr_done_spacing: done at cycle %0d want multiple of 3", c);
                end
                n_done++;
            end
            if (bus_fp.Gnt0) fp_gnt0++;
            if (bus_fp.Gnt1) fp_gnt1++;
        end
        bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus_fp.Req0 = 1'b0; bus_fp.Req1 = 1'b0;
        vectors++;
        if (n_gnt != 4 || n_done != 4) begin
            miscompares++;
            $display("FAIL rr_counts: gnts=%0d dones=%0d want 4 4", n_gnt, n_done);
        end
        vectors++;
        if (fp_gnt0 != 4 || fp_gnt1 != 0) begin
            miscompares++;
            $display("FAIL fp_gnts: gnt0=%0d gnt1=%0d want 4 0", fp_gnt0, fp_gnt1);
        end
        step; step; step;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 32'd12; bus.WData0 = 32'h12345678;
        model[12] = 32'h12345678;
        step;
        bus.Req0 = 1'b0;
        step;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 32'd12;
        step;
        bus.Req1 = 1'b0;
        step;
        Reset = 1'b1;
        step;
        vectors++;
        if ({bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1, bus.Err0, bus.Err1, bus.RData,
             bus.MemAddress, bus.MemWriteEnable, bus.MemRead} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: done=%b%b rdata=%h want all 0", bus.Done1, bus.Done0, bus.RData);
        end
        Reset = 1'b0;
        bus.Req1 = 1'b1;
        push_exp(1'b1, 1'b0, 1'b1, model[12]);
        step;
        vectors++;
        if (bus.Gnt1 !== 1'b1 || bus.MemRead !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_regnt: gnt1=%b rd=%b want 1 1", bus.Gnt1, bus.MemRead);
        end
        bus.Req1 = 1'b0;
        step; step;
        vectors++;
        e = sb.pop_front();
        if ({bus.Done1, bus.Done0} !== 2'b10 || bus.Err1 !== e.err || bus.RData !== e.rdata) begin
            miscompares++;
            $display("FAIL mid_reread: done=%b err1=%b rdata=%h want 10 0 %h",
                     {bus.Done1, bus.Done0}, bus.Err1, bus.RData, e.rdata);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        Reset = 1'b1;
        step;
        Reset = 1'b0;
        bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 32'd7; bus.WData0 = 32'hCAFE0007;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 32'd7;
        model[7] = 32'hCAFE0007;
        push_exp(1'b0, 1'b0, 1'b0, 32'h0);
        push_exp(1'b1, 1'b0, 1'b1, model[7]);
        step;
        vectors++;
        if ({bus.Gnt1, bus.Gnt0} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_gnt0: gnt=%b want 01", {bus.Gnt1, bus.Gnt0});
        end
        bus.Req0 = 1'b0;
        step;
        vectors++;
        e = sb.pop_front();
        if ({bus.Done1, bus.Done0} !== 2'b01 || bus.Err0 !== e.err || bus.Gnt1 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done0: done=%b err0=%b gnt1=%b want 01 0 0",
                     {bus.Done1, bus.Done0}, bus.Err0, bus.Gnt1);
        end
        step;
        vectors++;
        if ({bus.Gnt1, bus.Gnt0} !== 2'b10 || bus.MemRead !== 1'b1 || bus.MemAddress !== 32'd7) begin
            miscompares++;
            $display("FAIL b2b_gnt1: gnt=%b rd=%b maddr=%h want 10 1 7",
                     {bus.Gnt1, bus.Gnt0}, bus.MemRead, bus.MemAddress);
        end
        bus.Req1 = 1'b0;
        step; step;
        vectors++;
        e = sb.pop_front();
        if ({bus.Done1, bus.Done0} !== 2'b10 || bus.RData !== e.rdata) begin
            miscompares++;
            $display("FAIL b2b_done1: done=%b rdata=%h want 10 %h", {bus.Done1, bus.Done0}, bus.RData, e.rdata);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Reset = 1'b1;
        bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.We0 = 1'b0; bus.We1 = 1'b0;
        bus.Addr0 = '0; bus.Addr1 = '0; bus.WData0 = '0; bus.WData1 = '0;
        bus_fp.Req0 = 1'b0; bus_fp.Req1 = 1'b0; bus_fp.We0 = 1'b0; bus_fp.We1 = 1'b0;
        bus_fp.Addr0 = '0; bus_fp.Addr1 = '0; bus_fp.WData0 = '0; bus_fp.WData1 = '0;
        test_reset;
        test_write;
        test_read;
        test_out_of_range;
        test_arbitration;
        test_reset_mid;
        test_back_to_back;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d completions never seen", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data memory (1024 x 32, write and registered read on the rising Clock edge).
- Port 0: CPU load/store unit.
- Port 1: program loader/debug port.
- It picks one request, drives the memory control/address/data lines for exactly one cycle, captures the read word and returns a completion pulse to the owning port.

Parameters:
- DEPTH, 1024, memory words; legal word addresses are 0..DEPTH-1.
- AW, 10, memory address bits (log2 DEPTH).
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- Req0, Req1  in  1  request from port n.
- We0, We1  in  1  1 = write, 0 = read.
- Addr0, Addr1  in  32  word address.
- WData0, WData1  in  32  write data.
- Gnt0, Gnt1  out  1  one-cycle pulse: request accepted.
- Done0, Done1  out  1  one-cycle pulse: access complete.
- Err0, Err1  out  1  one-cycle pulse with Done: address out of range.
- RData  out  32  read data, valid while Done0 or Done1 is high for a read.
- MemAddress  out  32  to memory Address.
- MemWriteData  out  32  to memory WriteData.
- MemWriteEnable  out  1  to memory WriteEnable.
- MemRead  out  1  to memory MemRead.
- MemReadData  in  32  from memory ReadData.

Behaviour:
- Reset (sampled on the edge) values:
  - all outputs 0;
  - FSM = IDLE;
  - LastGrant = 1, so port 0 wins the first tie.
  - A reset mid-transaction drops it: no Done or Err. A memory write already issued on an earlier edge remains in memory.
- FSM states: IDLE, ISSUE, CAPTURE. All outputs are registered.
- IDLE:
  - If no Req, stay in IDLE.
  - Else select a winner:
    - Only one Req: that port wins.
    - Both Req, FIXED_PRIO=0: the winner is the port not equal to LastGrant.
    - Both Req, FIXED_PRIO=1: port 0 wins.
  - Latch We, Addr, WData and the owner ID, update LastGrant, pulse Gnt(owner) in the next cycle, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - In range (Addr < DEPTH):
    - MemAddress = {zeros, Addr[AW-1:0]}; MemWriteData = latched WData.
    - Write: MemWriteEnable = 1, MemRead = 0.
    - Read: MemWriteEnable = 0, MemRead = 1.
  - Out of range (Addr >= DEPTH):
    - MemWriteEnable = 0 and MemRead = 0; MemAddress = 0.
  - Next state:
    - Write or out of range: IDLE, with Done(owner) high in the following cycle. Err(owner) is also high if the address was out of range; RData = 0 in that case.
    - Read in range: CAPTURE.
- CAPTURE (1 cycle):
  - MemReadData is valid; all Mem* outputs are 0.
  - On the edge, RData <= MemReadData and Done(owner) pulses in the next cycle. Next state IDLE.
- Outside ISSUE, all Mem* outputs are 0.
- RData holds its last value until the next read completes; it is cleared only by reset or by an out-of-range completion.
- Timing (request first seen in IDLE at cycle T):
  - Gnt at T+1.
  - Memory sampled at the end of T+1.
  - Write or error: Done at T+2.
  - Read: Done and RData at T+3.
- Throughput: a new request can be accepted in the cycle Done is high, because the FSM is already in IDLE. Back-to-back reads take 3 cycles each; writes take 2.
- Requester rules:
  - Req, We, Addr and WData must stay stable from assertion until the cycle Gnt is high.
  - Req still high in the cycle after Gnt is treated as a new request.
  - A losing requester keeps Req high and waits; there is no timeout.
- Arbitration occurs only in IDLE. Requests that arrive while busy are ignored until the FSM returns to IDLE.
- With FIXED_PRIO=0, two continuous requesters alternate 0,1,0,1. With FIXED_PRIO=1, port 1 can starve; this is accepted by design.
- At most one Gnt, one Done and one Err bit is high in any cycle.

Test Plan:
1. Reset, then a port 0 write of Addr=5, WData=0xDEADBEEF:
   - Gnt0 at T+1 with MemWriteEnable=1, MemAddress=5.
   - Done0 at T+2, Err0=0.
2. Follow with a port 1 read of Addr=5:
   - Gnt1 at T+1 with MemRead=1.
   - Done1 at T+3 with RData=0xDEADBEEF; Done0 stays 0.
3. Req0 and Req1 held high from reset, FIXED_PRIO=0, all reads:
   - Gnt order 0,1,0,1; one Done every 3 cycles.
   - Rerun with FIXED_PRIO=1: only Gnt0 ever pulses.
4. Port 0 read of Addr=1024:
   - Gnt0, then Done0 and Err0 together at T+2, RData=0.
   - MemRead and MemWriteEnable are never high.
5. Assert Reset during CAPTURE of a read:
   - No Done0/Done1; all outputs 0 the next cycle.
   - A fresh read of the same address after reset completes normally.
6. A port 0 write to Addr=7 while Req1 (read of Addr 7) is pending:
   - Port 1 is granted only after Done0.
   - The read returns the newly written value.
